// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Requester IDs double as the round-robin last_grant encoding.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, and on a tie
// the requester that was not granted last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_id,
  output logic grant_valid
);

  assign grant_valid = req0 | req1;
  assign grant_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the
// debug/loader port, sequencing each access as a req/ready transaction.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_ack_o,
  output logic          err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ready_i,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  dmem_state_t   state;
  logic          owner;
  logic          last_grant;
  logic          grant_id;
  logic          grant_valid;
  logic [CW-1:0] cnt;
  logic          timed_out;

  rr_arb2 u_arb (
    .req0        (cpu_req_i),
    .req1        (dbg_req_i),
    .last_grant  (last_grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign timed_out   = (cnt == CW'(TIMEOUT));
  // The ack cycle is the one in which the pipeline advances.
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      owner       <= REQ_CPU;
      last_grant  <= REQ_DBG;
      cnt         <= '0;
      cpu_ack_o   <= 1'b0;
      dbg_ack_o   <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rdata_o <= '0;
      dbg_rdata_o <= '0;
    end else begin
      // Acks and err are single-cycle pulses that cover the RESP state only.
      cpu_ack_o <= 1'b0;
      dbg_ack_o <= 1'b0;
      err_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ACCESS;
            owner      <= grant_id;
            last_grant <= grant_id;
            cnt        <= CW'(1);
            mem_req_o  <= 1'b1;
            if (grant_id == REQ_DBG) begin
              mem_we_o    <= dbg_we_i;
              mem_addr_o  <= dbg_addr_i;
              mem_wdata_o <= dbg_wdata_i;
            end else begin
              mem_we_o    <= cpu_we_i;
              mem_addr_o  <= cpu_addr_i;
              mem_wdata_o <= cpu_wdata_i;
            end
          end
        end
        ACCESS: begin
          if (mem_ready_i || timed_out) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            cnt       <= '0;
            if (owner == REQ_DBG) dbg_ack_o <= 1'b1;
            else                  cpu_ack_o <= 1'b1;
            // Ready on the final cycle still counts as a clean completion.
            if (mem_ready_i) begin
              if (owner == REQ_DBG) dbg_rdata_o <= mem_rdata_i;
              else                  cpu_rdata_o <= mem_rdata_i;
            end else begin
              err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// transaction-level run against a round-robin/latency reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i, mem_ready_i;
  logic [AW-1:0] cpu_addr_i, dbg_addr_i;
  logic [DW-1:0] cpu_wdata_i, dbg_wdata_i, mem_rdata_i;
  logic [DW-1:0] cpu_rdata_o, dbg_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          cpu_ack_o, cpu_stall_o, dbg_ack_o, err_o, mem_req_o, mem_we_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who was granted last and each requester's held load data.
  logic          exp_last;
  logic [DW-1:0] exp_cpu_rd, exp_dbg_rd;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
    .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    #2 rst_n = 1'b1;
    exp_last = REQ_DBG; exp_cpu_rd = '0; exp_dbg_rd = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we_o); end
    n_checks++; if ({cpu_ack_o, dbg_ack_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {cpu_ack_o, dbg_ack_o, err_o}); end
    n_checks++; if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr_o, mem_wdata_o); end
    n_checks++; if (cpu_rdata_o !== '0 || dbg_rdata_o !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata_o, dbg_rdata_o); end
    n_checks++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall_o); end
  endtask

  task automatic test_cpu_load();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    #1;
    n_checks++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL load_stall_c0: got %b want 1", cpu_stall_o); end
    tick();
    n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL load_mem_c1: got req=%b we=%b addr=%h want 1 0 00000100", mem_req_o, mem_we_o, mem_addr_o); end
    n_checks++; if (cpu_stall_o !== 1'b1 || cpu_ack_o !== 1'b0) begin n_fail++; $display("FAIL load_stall_c1: got stall=%b ack=%b want 1 0", cpu_stall_o, cpu_ack_o); end
    mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    tick();
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    n_checks++; if (cpu_ack_o !== 1'b1 || cpu_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_ack_c2: got ack=%b data=%h want 1 deadbeef", cpu_ack_o, cpu_rdata_o); end
    n_checks++; if (cpu_stall_o !== 1'b0 || err_o !== 1'b0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL load_c2_ctl: got stall=%b err=%b req=%b want 0 0 0", cpu_stall_o, err_o, mem_req_o); end
    exp_cpu_rd = 32'hDEADBEEF; exp_last = REQ_CPU;
    cpu_req_i = 1'b0;
    tick();
    n_checks++; if (cpu_ack_o !== 1'b0) begin n_fail++; $display("FAIL load_ack_pulse: got %b want 0", cpu_ack_o); end
  endtask

  task automatic test_tie();
    do_reset();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h40; dbg_wdata_i = 32'h12345678;
    tick();
    n_checks++; if (mem_we_o !== 1'b0 || mem_addr_o !== 32'h80) begin n_fail++; $display("FAIL tie_first_grant: got we=%b addr=%h want 0 00000080", mem_we_o, mem_addr_o); end
    mem_ready_i = 1'b1; mem_rdata_i = 32'hA5A50001;
    tick();
    mem_ready_i = 1'b0;
    n_checks++; if (cpu_ack_o !== 1'b1 || dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL tie_cpu_ack: got cpu=%b dbg=%b want 1 0", cpu_ack_o, dbg_ack_o); end
    cpu_req_i = 1'b0;
    tick();
    tick();
    n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h40 || mem_wdata_o !== 32'h12345678) begin n_fail++; $display("FAIL tie_dbg_mem: got req=%b we=%b addr=%h wd=%h want 1 1 00000040 12345678", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
    n_checks++; if (dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL tie_dbg_early: got %b want 0", dbg_ack_o); end
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD0002;
    tick();
    mem_ready_i = 1'b0;
    n_checks++; if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h0BAD0002) begin n_fail++; $display("FAIL tie_dbg_ack_c5: got ack=%b data=%h want 1 0bad0002", dbg_ack_o, dbg_rdata_o); end
    n_checks++; if (cpu_rdata_o !== 32'hA5A50001) begin n_fail++; $display("FAIL tie_cpu_rdata_held: got %h want a5a50001", cpu_rdata_o); end
    exp_cpu_rd = 32'hA5A50001; exp_dbg_rd = 32'h0BAD0002; exp_last = REQ_DBG;
    dbg_req_i = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic          want;
    logic [DW-1:0] rd;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h200;
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h300;
    for (int t = 0; t < 4; t++) begin
      want = ~exp_last;
      tick();
      n_checks++; if (mem_addr_o !== (want ? 32'h300 : 32'h200)) begin n_fail++; $display("FAIL alt_grant_%0d: got addr=%h want %h", t, mem_addr_o, want ? 32'h300 : 32'h200); end
      rd = $urandom;
      mem_ready_i = 1'b1; mem_rdata_i = rd;
      tick();
      mem_ready_i = 1'b0;
      n_checks++; if (cpu_ack_o !== ~want || dbg_ack_o !== want) begin n_fail++; $display("FAIL alt_ack_%0d: got cpu=%b dbg=%b want %b %b", t, cpu_ack_o, dbg_ack_o, ~want, want); end
      if (want) exp_dbg_rd = rd; else exp_cpu_rd = rd;
      exp_last = want;
      tick();
    end
    cpu_req_i = 1'b0; dbg_req_i = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h44;
    tick();
    exp_last = REQ_CPU;
    for (int c = 1; c <= TO; c++) begin
      if (mem_req_o !== 1'b1 || cpu_ack_o !== 1'b0) bad++;
      mem_rdata_i = $urandom;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL timeout_access_len: got %0d bad ACCESS cycles want 0", bad); end
    n_checks++; if (cpu_ack_o !== 1'b1 || err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_ack_err: got ack=%b err=%b want 1 1", cpu_ack_o, err_o); end
    n_checks++; if (cpu_rdata_o !== exp_cpu_rd) begin n_fail++; $display("FAIL timeout_rdata_held: got %h want %h", cpu_rdata_o, exp_cpu_rd); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL timeout_req_drop: got %b want 0", mem_req_o); end
    cpu_req_i = 1'b0;
    tick();
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b want 0", err_o); end
  endtask

  task automatic test_ready_on_last();
    logic [DW-1:0] rd;
    rd = 32'hC0FFEE16;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h48;
    tick();
    exp_last = REQ_CPU;
    for (int c = 1; c <= TO; c++) begin
      mem_ready_i = (c == TO);
      mem_rdata_i = (c == TO) ? rd : 32'h0;
      tick();
    end
    mem_ready_i = 1'b0;
    n_checks++; if (cpu_ack_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL last_ready_ack_err: got ack=%b err=%b want 1 0", cpu_ack_o, err_o); end
    n_checks++; if (cpu_rdata_o !== rd) begin n_fail++; $display("FAIL last_ready_data: got %h want %h", cpu_rdata_o, rd); end
    exp_cpu_rd = rd;
    cpu_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h7C; dbg_wdata_i = 32'h55AA55AA;
    tick();
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h7C) begin n_fail++; $display("FAIL rstmid_dbg_grant: got req=%b addr=%h want 1 0000007c", mem_req_o, mem_addr_o); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_drop: got %b want 0", mem_req_o); end
    tick();
    tick();
    n_checks++; if ({cpu_ack_o, dbg_ack_o, err_o} !== 3'b000) begin n_fail++; $display("FAIL rstmid_no_ack: got %b want 000", {cpu_ack_o, dbg_ack_o, err_o}); end
    #2 rst_n = 1'b1;
    exp_last = REQ_DBG; exp_cpu_rd = '0; exp_dbg_rd = '0;
    n_checks++; if (mem_addr_o !== '0 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_clear: got addr=%h we=%b want 0 0", mem_addr_o, mem_we_o); end
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h88;
    tick();
    n_checks++; if (mem_addr_o !== 32'h88 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_cpu_tie: got addr=%h we=%b want 00000088 0", mem_addr_o, mem_we_o); end
    exp_last = REQ_CPU;
    mem_ready_i = 1'b1; mem_rdata_i = 32'h13572468;
    tick();
    mem_ready_i = 1'b0;
    n_checks++; if (cpu_ack_o !== 1'b1 || dbg_ack_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_cpu_ack: got cpu=%b dbg=%b want 1 0", cpu_ack_o, dbg_ack_o); end
    exp_cpu_rd = 32'h13572468;
    cpu_req_i = 1'b0; dbg_req_i = 1'b0;
    tick();
  endtask

  task automatic test_random(input int n);
    logic          cr, dr, cw, dw, win, tmo;
    logic [AW-1:0] ca, da, want_addr;
    logic [DW-1:0] cd, dd, rd, want_wd;
    int            lat, bad;
    for (int it = 0; it < n; it++) begin
      {dr, cr} = 2'($urandom_range(1, 3));
      cw = 1'($urandom); dw = 1'($urandom);
      ca = $urandom; da = $urandom; cd = $urandom; dd = $urandom;
      lat = $urandom_range(1, TO + 2);
      win = (cr && dr) ? ~exp_last : dr;
      tmo = (lat > TO);
      want_addr = win ? da : ca;
      want_wd   = win ? dd : cd;
      // ready noise while idle must be ignored
      mem_ready_i = 1'($urandom); mem_rdata_i = $urandom;
      cpu_req_i = cr; cpu_we_i = cw; cpu_addr_i = ca; cpu_wdata_i = cd;
      dbg_req_i = dr; dbg_we_i = dw; dbg_addr_i = da; dbg_wdata_i = dd;
      #1;
      n_checks++; if (cpu_stall_o !== cr) begin n_fail++; $display("FAIL rnd%0d_stall_idle: got %b want %b", it, cpu_stall_o, cr); end
      tick();
      n_checks++; if (mem_req_o !== 1'b1 || mem_we_o !== (win ? dw : cw) || mem_addr_o !== want_addr || mem_wdata_o !== want_wd) begin
        n_fail++; $display("FAIL rnd%0d_grant: got req=%b we=%b addr=%h wd=%h want 1 %b %h %h", it, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, win ? dw : cw, want_addr, want_wd);
      end
      exp_last = win;
      bad = 0;
      rd = '0;
      for (int c = 1; c <= TO; c++) begin
        rd = $urandom;
        mem_rdata_i = rd;
        mem_ready_i = (c == lat);
        tick();
        if (c == lat || c == TO) break;
        if (mem_req_o !== 1'b1 || cpu_ack_o !== 1'b0 || dbg_ack_o !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_access_hold: got %0d bad cycles want 0", it, bad); end
      if (!tmo) begin
        if (win) exp_dbg_rd = rd; else exp_cpu_rd = rd;
      end
      mem_ready_i = 1'($urandom); mem_rdata_i = $urandom;
      n_checks++; if (cpu_ack_o !== ~win || dbg_ack_o !== win || err_o !== tmo) begin
        n_fail++; $display("FAIL rnd%0d_resp: got cpu=%b dbg=%b err=%b want %b %b %b (lat %0d)", it, cpu_ack_o, dbg_ack_o, err_o, ~win, win, tmo, lat);
      end
      n_checks++; if (cpu_rdata_o !== exp_cpu_rd || dbg_rdata_o !== exp_dbg_rd) begin
        n_fail++; $display("FAIL rnd%0d_rdata: got %h/%h want %h/%h", it, cpu_rdata_o, dbg_rdata_o, exp_cpu_rd, exp_dbg_rd);
      end
      n_checks++; if (cpu_stall_o !== (cr & win)) begin n_fail++; $display("FAIL rnd%0d_stall_resp: got %b want %b", it, cpu_stall_o, cr & win); end
      cpu_req_i = 1'b0; dbg_req_i = 1'b0;
      tick();
      mem_ready_i = 1'b0;
      n_checks++; if ({cpu_ack_o, dbg_ack_o, err_o, mem_req_o} !== 4'b0000) begin n_fail++; $display("FAIL rnd%0d_idle: got %b want 0000", it, {cpu_ack_o, dbg_ack_o, err_o, mem_req_o}); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_load();
    test_tie();
    test_alternate();
    test_timeout();
    test_ready_on_last();
    test_reset_mid_access();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single data-memory port. It shares the data memory between the CPU MEM stage (requester 0) and the debug/loader port (requester 1), and runs each access as a request/ready transaction toward a variable-latency memory. While a CPU access is pending it drives a stall that freezes the pipeline. It sits between the EX/MEM pipeline register and the data memory, replacing the direct MemRead/MemWrite connection.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT`, default 16: maximum cycles spent in ACCESS before abort. Must be at least 2.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `cpu_req_i` input 1: CPU MEM-stage access request (MemRead_MEM | MemWrite_MEM).
- `cpu_we_i` input 1: CPU access is a write.
- `cpu_addr_i` input AW: CPU address (ALU result in MEM).
- `cpu_wdata_i` input DW: CPU store data.
- `cpu_rdata_o` output DW: CPU load data, valid while `cpu_ack_o` is high.
- `cpu_ack_o` output 1: one-cycle completion pulse to the CPU.
- `cpu_stall_o` output 1: freeze PC and all pipeline registers.
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i`: debug request, same semantics as the CPU inputs.
- `dbg_rdata_o` output DW: debug load data, held until the next debug ack.
- `dbg_ack_o` output 1: one-cycle completion pulse to debug.
- `err_o` output 1: pulses together with an ack when that access timed out.
- `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`: memory-side request; all registered.
- `mem_ready_i` input 1: memory completion. Read data is valid in the same cycle.
- `mem_rdata_i` input DW: memory read data.

## Operation
- FSM states:
  - IDLE → ACCESS when any request is present.
  - ACCESS → RESP on `mem_ready_i`, or on timeout.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE only.
  - A single requester wins outright.
  - When both request, the requester not granted last wins (round-robin).
  - The `last_grant` register updates on each grant.
  - Reset value of `last_grant` is DBG, so the CPU wins the first tie.
- On grant, the winner's we/addr/wdata are latched into `mem_*_o` and its ID is latched into `owner`. Inputs are not re-sampled until the next IDLE.
- ACCESS:
  - `mem_req_o` = 1.
  - The timeout counter counts from 1.
  - On `mem_ready_i`: capture `mem_rdata_i` into the owner's rdata register and clear `mem_req_o`.
  - If the counter reaches TIMEOUT without ready: clear `mem_req_o`, set the error flag, leave the owner's rdata unchanged.
- RESP:
  - Pulse the owner's ack.
  - Pulse `err_o` if the error flag is set.
  - Clear the error flag.
- `cpu_stall_o` = `cpu_req_i` & ~`cpu_ack_o` (combinational). This covers both the arbitration loss and the access latency.
- A request still high in IDLE after its ack is treated as a new access. The CPU drops it naturally because the pipeline advances in the ack cycle.
- Reset values:
  - State IDLE, `owner` = CPU.
  - All acks, `err_o`, `mem_req_o` and `mem_we_o` = 0.
  - Addresses, wdata and rdata registers = 0.
  - Counter = 0.
- Reset asserted mid-ACCESS: `mem_req_o` drops immediately (asynchronous). No ack or err is issued for the aborted access.

## Timing
- Cycle 0: IDLE with a request present.
- Cycle 1: ACCESS, `mem_req_o` = 1.
- First cycle with `mem_ready_i` = 1 (cycle k ≥ 1): the next cycle is RESP with ack.
- Minimum latency is request to ack = 2 cycles.
- Throughput is at most one access per 3 cycles (IDLE, ACCESS, RESP).
- A losing requester waits for the full transaction, then wins the next IDLE.
- `mem_ready_i` outside ACCESS is ignored.
- `mem_ready_i` and timeout in the same cycle: ready wins, with no error.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then RESP with `err_o` = 1.

## Structure
- A shared package holds:
  - `dmem_state_t` enum {IDLE, ACCESS, RESP}.
  - Requester ID constants `REQ_CPU` = 0 and `REQ_DBG` = 1.
  - Default TIMEOUT.
- One natural sub-module: `rr_arb2`, a combinational two-way round-robin pick from (req0, req1, last_grant) producing grant_id and grant_valid.
- The FSM, registers and timeout counter stay in the top.

## Test plan
- CPU load alone, `mem_ready_i` on the 1st ACCESS cycle, `mem_rdata_i` = 0xDEADBEEF:
  - `cpu_ack_o` at cycle 2 with `cpu_rdata_o` = 0xDEADBEEF.
  - `cpu_stall_o` high in cycles 0–1, low in cycle 2.
- Simultaneous CPU read and debug write at 0x40 with data 0x12345678, memory ready after 1 cycle:
  - CPU granted first (reset tie rule).
  - Debug `mem_we_o` = 1 and `mem_addr_o` = 0x40 in the following transaction.
  - Debug ack 3 cycles after the CPU ack.
- Both requesting continuously for 4 transactions: grants alternate CPU, DBG, CPU, DBG.
- `mem_ready_i` held low with TIMEOUT = 16:
  - ACCESS lasts 16 cycles.
  - RESP pulses `cpu_ack_o` and `err_o` together.
  - `cpu_rdata_o` keeps its prior value.
- `mem_ready_i` arriving exactly on the 16th ACCESS cycle: ack with `err_o` = 0 and the data captured.
- `rst_i` low during ACCESS, debug owner:
  - `mem_req_o` drops without waiting for a clock edge.
  - No ack or err is issued.
  - After release, the next tie is granted to the CPU.
